aes_input_packer: RTL and testbench
===================================

AES_INPUT_PACKER -- requirements
Module: aes_input_packer

Interface
REQ-001 SHALL have parameter WORD_W, default 32, input word width; only 32 is supported.
REQ-002 SHALL have parameter BLK_W, default 128, block width; equals 4*WORD_W.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port clear  input  1  synchronous flush of partial and held data.
REQ-006 SHALL have port s_data  input  32  plaintext word.
REQ-007 SHALL have port s_valid  input  1  s_data valid.
REQ-008 SHALL have port s_ready  output  1  packer accepts a word this cycle.
REQ-009 SHALL have port m_block  output  128  packed block to the encrypt core's in port.
REQ-010 SHALL have port m_valid  output  1  m_block valid.
REQ-011 SHALL have port m_ready  input  1  downstream consumes m_block this cycle.
REQ-012 SHALL have port fill_cnt  output  3  words in assembly register, 0..4.

Function
REQ-013 SHALL accept a word on any edge where s_valid && s_ready.
REQ-014 SHALL pack big-endian: 1st word -> bits [127:96], 2nd -> [95:64], 3rd -> [63:32], 4th -> [31:0].
REQ-015 SHALL hold two storage stages: assembly register (fill_cnt 0..4) and output register (m_valid).
REQ-016 SHALL transfer assembly to output on the edge where fill_cnt reaches 4 if output is empty or consumed (m_valid && m_ready) that same edge; fill_cnt then returns to 0.
REQ-017 SHALL, when 4th word arrives while output is held and not consumed, keep fill_cnt=4 and transfer on the first edge output frees.
REQ-018 SHALL drive s_ready = !(fill_cnt==4), registered-state only, no combinational path from s_valid.
REQ-019 SHALL present a block on m_block/m_valid exactly 1 cycle after its 4th word is accepted when output is free.
REQ-020 SHALL keep m_block and m_valid stable while m_valid && !m_ready.
REQ-021 SHALL clear m_valid on consumption unless a new block transfers that same edge (back-to-back blocks, no bubble).
REQ-022 SHALL sustain one word per cycle continuously when m_ready is held high.
REQ-023 SHALL on clear set fill_cnt=0, m_valid=0, discard partial and held data; clear overrides a simultaneous s_valid word and transfer.

Reset
REQ-024 SHALL on rst asserted set fill_cnt=0, m_valid=0, m_block=0, assembly register=0, chain register=0, immediately without clock.
REQ-025 SHALL drive s_ready=1 from the first edge after rst deasserts.
REQ-026 SHALL discard any partial block when rst asserts mid-fill; no word from before reset emerges afterward.

Configuration
REQ-027 SHALL support macro AES_CBC_XOR_EN.
REQ-028 SHALL with AES_CBC_XOR_EN add ports iv 128 in, iv_load 1 in, fb_block 128 in, fb_valid 1 in, plus a 128-bit chain register.
REQ-029 SHALL with AES_CBC_XOR_EN load chain from iv on iv_load, else from fb_block on fb_valid; iv_load has priority.
REQ-030 SHALL with AES_CBC_XOR_EN write output register = assembly ^ chain at transfer time, chain value sampled as of that edge (pre-update).
REQ-031 SHALL without AES_CBC_XOR_EN omit those ports and chain register and transfer assembly unmodified.

Verification
REQ-032 SHALL test: words 0x00112233,0x44556677,0x8899AABB,0xCCDDEEFF on 4 consecutive cycles, m_ready=1 -> next cycle m_valid=1, m_block=0x00112233_44556677_8899AABB_CCDDEEFF.
REQ-033 SHALL test: m_ready=0, send 8 words -> after 8th accepted fill_cnt=4, s_ready=0, first block held stable; raise m_ready 1 cycle -> second block appears next cycle, s_ready=1.
REQ-034 SHALL test: 12 words streamed, m_ready=1 -> 3 blocks, m_valid high on 3 distinct cycles spaced 4 cycles apart, no dropped word.
REQ-035 SHALL test: 2 words then rst pulse mid-cycle -> fill_cnt=0, m_valid=0 immediately; next 4 words form the only block.
REQ-036 SHALL test: 3 words, clear with 4th word same cycle -> fill_cnt=0, no block emitted.
REQ-037 SHALL test (AES_CBC_XOR_EN): iv_load iv=0x000102030405060708090A0B0C0D0E0F, block of all-zero words -> m_block=iv; fb_valid with 0xFF..FF then zero block -> m_block=0xFF..FF.

Source files
------------

// File: rtl/aes_input_packer.sv
// Packs four 32-bit plaintext words (big-endian) into a 128-bit block with a one-deep output stage.
// Optional CBC pre-whitening with a chain register is enabled by defining AES_CBC_XOR_EN.
module aes_input_packer #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned BLK_W  = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [BLK_W-1:0]  m_block,
    output logic              m_valid,
    input  logic              m_ready,
`ifdef AES_CBC_XOR_EN
    input  logic [BLK_W-1:0]  iv,
    input  logic              iv_load,
    input  logic [BLK_W-1:0]  fb_block,
    input  logic              fb_valid,
`endif
    output logic [2:0]        fill_cnt
);

    logic [BLK_W-1:0] asm_q, asm_d;
    logic [BLK_W-1:0] out_q, out_d;
    logic [2:0]       fill_q, fill_d;
    logic             m_valid_q, m_valid_d;
    logic             accept;
    logic             out_free;
    logic [2:0]       fill_next;
    logic [BLK_W-1:0] asm_next;
    logic [BLK_W-1:0] xfer_blk;

`ifdef AES_CBC_XOR_EN
    logic [BLK_W-1:0] chain_q, chain_d;

    always_comb begin
        chain_d = chain_q;
        if (iv_load) begin
            chain_d = iv;
        end else if (fb_valid) begin
            chain_d = fb_block;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign xfer_blk = asm_next ^ chain_q;
`else
    assign xfer_blk = asm_next;
`endif

    assign s_ready  = (fill_q != 3'd4);
    assign accept   = s_valid && s_ready;
    assign out_free = !m_valid_q || m_ready;
    assign fill_cnt = fill_q;
    assign m_valid  = m_valid_q;
    assign m_block  = out_q;

    // Insert the incoming word into its big-endian slot before deciding on a transfer.
    always_comb begin
        asm_next  = asm_q;
        fill_next = fill_q;
        if (accept) begin
            fill_next = fill_q + 3'd1;
            case (fill_q)
                3'd0:    asm_next[BLK_W-1 -: WORD_W]          = s_data;
                3'd1:    asm_next[BLK_W-1-WORD_W -: WORD_W]   = s_data;
                3'd2:    asm_next[BLK_W-1-2*WORD_W -: WORD_W] = s_data;
                3'd3:    asm_next[BLK_W-1-3*WORD_W -: WORD_W] = s_data;
                default: asm_next = asm_q;
            endcase
        end
    end

    always_comb begin
        asm_d     = asm_next;
        fill_d    = fill_next;
        out_d     = out_q;
        m_valid_d = m_valid_q;
        if (clear) begin
            asm_d     = '0;
            fill_d    = 3'd0;
            out_d     = '0;
            m_valid_d = 1'b0;
        end else if (fill_next == 3'd4 && out_free) begin
            out_d     = xfer_blk;
            m_valid_d = 1'b1;
            asm_d     = '0;
            fill_d    = 3'd0;
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_q     <= '0;
            out_q     <= '0;
            fill_q    <= 3'd0;
            m_valid_q <= 1'b0;
        end else begin
            asm_q     <= asm_d;
            out_q     <= out_d;
            fill_q    <= fill_d;
            m_valid_q <= m_valid_d;
        end
    end

endmodule

// File: tb/tb_aes_input_packer.sv
// Scoreboard bench for aes_input_packer: a word-queue reference model predicts blocks,
// an independent monitor pops and compares on every output handshake.
module tb_aes_input_packer;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic [31:0]   s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [127:0]  m_block;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [2:0]    fill_cnt;
`ifdef AES_CBC_XOR_EN
    logic [127:0]  iv = '0;
    logic          iv_load = 1'b0;
    logic [127:0]  fb_block = '0;
    logic          fb_valid = 1'b0;
`endif

    aes_input_packer #(.WORD_W(32), .BLK_W(128)) dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .m_block  (m_block),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
`ifdef AES_CBC_XOR_EN
        .iv       (iv),
        .iv_load  (iv_load),
        .fb_block (fb_block),
        .fb_valid (fb_valid),
`endif
        .fill_cnt (fill_cnt)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc = 0;
    int unsigned pops = 0;
    int unsigned epoch = 0;

    // Reference model: words waiting for a block, whether the output slot is occupied,
    // and the chain value applied at transfer time.
    logic [31:0]  mdl_words[$];
    logic         mdl_occ = 1'b0;
    logic [127:0] mdl_chain = '0;
    logic [127:0] exp_q[$];
    int unsigned  pop_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mdl_words.delete();
        mdl_occ   = 1'b0;
        mdl_chain = '0;
        exp_q.delete();
    endtask

    // One clock cycle: drive at negedge, check pre-edge state, advance the model.
    task automatic step(input logic sv, input logic [31:0] d, input logic mr, input logic clr);
        logic         acc;
        logic [127:0] blk;
        @(negedge clk);
        s_valid = sv;
        s_data  = d;
        m_ready = mr;
        clear   = clr;
        #2;
        chk("fill_cnt", 128'(fill_cnt), 128'(mdl_words.size()));
        chk("s_ready", 128'(s_ready), 128'(mdl_words.size() < 4));
        chk("m_valid", 128'(m_valid), 128'(mdl_occ));
        if (clr) begin
            mdl_words.delete();
            mdl_occ = 1'b0;
            exp_q.delete();
        end else begin
            acc = sv && (mdl_words.size() < 4);
            if (mdl_occ && mr) mdl_occ = 1'b0;
            if (acc) mdl_words.push_back(d);
            if (mdl_words.size() == 4 && !mdl_occ) begin
                blk = {mdl_words[0], mdl_words[1], mdl_words[2], mdl_words[3]} ^ mdl_chain;
                exp_q.push_back(blk);
                mdl_words.delete();
                mdl_occ = 1'b1;
            end
        end
`ifdef AES_CBC_XOR_EN
        if (iv_load) mdl_chain = iv;
        else if (fb_valid) mdl_chain = fb_block;
`endif
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_fill_cnt", 128'(fill_cnt), 128'd0);
        chk("rst_m_valid", 128'(m_valid), 128'd0);
        chk("rst_m_block", m_block, 128'd0);
        #1 rst = 1'b0;
        epoch++;
        model_reset();
    endtask

    // Monitor: compares every consumed block against the scoreboard and checks hold stability.
    logic         prev_hold = 1'b0;
    logic [127:0] prev_block = '0;
    int unsigned  prev_epoch = 0;

    always @(negedge clk) begin
        #1;
        if (!rst) begin
            if (prev_hold && prev_epoch == epoch) begin
                chk("hold_m_valid", 128'(m_valid), 128'd1);
                chk("hold_m_block", m_block, prev_block);
            end
            if (m_valid && m_ready && !clear) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_block", m_block, 128'hx);
                end else begin
                    chk("block", m_block, exp_q.pop_front());
                end
                pops++;
                pop_cyc.push_back(cyc);
            end
            prev_hold  = m_valid && !m_ready && !clear;
            prev_block = m_block;
            prev_epoch = epoch;
        end
    end

    logic [31:0]  w[12];
    logic [127:0] blk_a, blk_b;
    int unsigned  pops0;

    initial begin
        #12 rst = 1'b0;
        model_reset();
        chk("init_fill_cnt", 128'(fill_cnt), 128'd0);
        chk("init_m_valid", 128'(m_valid), 128'd0);
        chk("init_s_ready", 128'(s_ready), 128'd1);

        // Single block, one word per cycle.
        step(1'b1, 32'h00112233, 1'b1, 1'b0);
        step(1'b1, 32'h44556677, 1'b1, 1'b0);
        step(1'b1, 32'h8899AABB, 1'b1, 1'b0);
        step(1'b1, 32'hCCDDEEFF, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t32_m_valid", 128'(m_valid), 128'd1);
        chk("t32_m_block", m_block, 128'h00112233_44556677_8899AABB_CCDDEEFF);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Backpressure: eight words with the output stalled.
        for (int i = 0; i < 8; i++) w[i] = $urandom;
        blk_a = {w[0], w[1], w[2], w[3]};
        blk_b = {w[4], w[5], w[6], w[7]};
        for (int i = 0; i < 8; i++) step(1'b1, w[i], 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t33_fill_cnt", 128'(fill_cnt), 128'd4);
        chk("t33_s_ready", 128'(s_ready), 128'd0);
        chk("t33_block_a", m_block, blk_a);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("t33_m_valid_b", 128'(m_valid), 128'd1);
        chk("t33_block_b", m_block, blk_b);
        chk("t33_s_ready_b", 128'(s_ready), 128'd1);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Streaming: twelve words back to back.
        pop_cyc.delete();
        for (int i = 0; i < 12; i++) step(1'b1, $urandom, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t34_blocks", 128'(pop_cyc.size()), 128'd3);
        if (pop_cyc.size() == 3) begin
            chk("t34_gap1", 128'(pop_cyc[1] - pop_cyc[0]), 128'd4);
            chk("t34_gap2", 128'(pop_cyc[2] - pop_cyc[1]), 128'd4);
        end

        // Reset mid-fill discards the partial block.
        step(1'b1, 32'hDEAD0001, 1'b1, 1'b0);
        step(1'b1, 32'hDEAD0002, 1'b1, 1'b0);
        pulse_reset();
        pops0 = pops;
        step(1'b1, 32'h01010101, 1'b1, 1'b0);
        step(1'b1, 32'h02020202, 1'b1, 1'b0);
        step(1'b1, 32'h03030303, 1'b1, 1'b0);
        step(1'b1, 32'h04040404, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t35_block", m_block, 128'h01010101_02020202_03030303_04040404);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t35_one_block", 128'(pops - pops0), 128'd1);

        // Clear coinciding with the fourth word.
        pops0 = pops;
        step(1'b1, 32'hA0A0A0A0, 1'b1, 1'b0);
        step(1'b1, 32'hA1A1A1A1, 1'b1, 1'b0);
        step(1'b1, 32'hA2A2A2A2, 1'b1, 1'b0);
        step(1'b1, 32'hA3A3A3A3, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t36_fill_cnt", 128'(fill_cnt), 128'd0);
        chk("t36_m_valid", 128'(m_valid), 128'd0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t36_no_block", 128'(pops - pops0), 128'd0);

        // Randomized traffic with backpressure and occasional flushes.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 49) == 0);
        end
        for (int i = 0; i < 8 && (exp_q.size() != 0 || mdl_occ); i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b0);
        end
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("drain_empty", 128'(exp_q.size()), 128'd0);

`ifdef AES_CBC_XOR_EN
        iv      = 128'h000102030405060708090A0B0C0D0E0F;
        iv_load = 1'b1;
        step(1'b0, 32'h0, 1'b1, 1'b0);
        iv_load = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b1, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t37_iv_block", m_block, 128'h000102030405060708090A0B0C0D0E0F);
        fb_block = '1;
        fb_valid = 1'b1;
        step(1'b0, 32'h0, 1'b1, 1'b0);
        fb_valid = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b1, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t37_fb_block", m_block, {128{1'b1}});
        step(1'b0, 32'h0, 1'b1, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
